// File: rtl/urv_csr_bank_if.sv
// Debug mailbox handshake bundle between the CSR bank (slave) and the host (master).
interface urv_csr_bank_if;
    logic [31:0] dbg_mbx_data_i;
    logic        dbg_mbx_valid_i;
    logic        dbg_mbx_ready_o;
    logic [31:0] dbg_mbx_data_o;
    logic        dbg_mbx_valid_o;
    logic        dbg_mbx_ack_i;

    modport slave (
        input  dbg_mbx_data_i, dbg_mbx_valid_i, dbg_mbx_ack_i,
        output dbg_mbx_ready_o, dbg_mbx_data_o, dbg_mbx_valid_o
    );

    modport master (
        output dbg_mbx_data_i, dbg_mbx_valid_i, dbg_mbx_ack_i,
        input  dbg_mbx_ready_o, dbg_mbx_data_o, dbg_mbx_valid_o
    );
endinterface

// File: rtl/urv_csr_bank.sv
// uRV CSR bank: scratch regs, cycle/instret counters, optional debug mailbox.
// Define URV_CSR_INSTRET_EN to build the instret counter.
`ifndef CSR_ID_MSCRATCH
`define CSR_ID_MSCRATCH    12'h340
`endif
`ifndef CSR_ID_MSTATUS
`define CSR_ID_MSTATUS     12'h300
`endif
`ifndef CSR_ID_MIE
`define CSR_ID_MIE         12'h304
`endif
`ifndef CSR_ID_MEPC
`define CSR_ID_MEPC        12'h341
`endif
`ifndef CSR_ID_MCAUSE
`define CSR_ID_MCAUSE      12'h342
`endif
`ifndef CSR_ID_MIP
`define CSR_ID_MIP         12'h344
`endif
`ifndef CSR_ID_CYCLESL
`define CSR_ID_CYCLESL     12'hC00
`endif
`ifndef CSR_ID_CYCLESH
`define CSR_ID_CYCLESH     12'hC80
`endif
`ifndef CSR_ID_INSTRETL
`define CSR_ID_INSTRETL    12'hC02
`endif
`ifndef CSR_ID_INSTRETH
`define CSR_ID_INSTRETH    12'hC82
`endif
`ifndef CSR_ID_DBGMBX
`define CSR_ID_DBGMBX      12'h7D0
`endif
`ifndef CSR_ID_DBGMBX_STAT
`define CSR_ID_DBGMBX_STAT 12'h7D1
`endif

module urv_csr_bank #(
    parameter int g_num_scratch   = 1,
    parameter int g_counter_width = 40,
    parameter int g_with_hw_debug = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       x_stall_i,
    input  logic                       x_kill_i,
    input  logic                       x_retire_i,
    input  logic                       d_is_csr_i,
    input  logic [2:0]                 d_fun_i,
    input  logic [4:0]                 d_csr_imm_i,
    input  logic [11:0]                d_csr_sel_i,
    input  logic [31:0]                d_rs1_i,
    output logic [31:0]                x_rd_o,
    output logic [31:0]                x_csr_write_value_o,
    input  logic [31:0]                csr_mstatus_i,
    input  logic [31:0]                csr_mip_i,
    input  logic [31:0]                csr_mie_i,
    input  logic [31:0]                csr_mepc_i,
    input  logic [31:0]                csr_mcause_i,
    output logic [g_counter_width-1:0] csr_cycles_o,
    urv_csr_bank_if.slave              mbx
);
    localparam int W = g_counter_width;

    logic        commit;
    logic [31:0] op2;
    logic [31:0] wval;
    logic [31:0] rd;
    logic [31:0] instret_l;
    logic [31:0] instret_h;
    logic [31:0] mbx_rd;
    logic [31:0] mbx_stat;

    logic [31:0]  scratch_q [g_num_scratch];
    logic [W-1:0] cycles_q, cycles_d;

    function automatic logic [11:0] scr_addr(input int k);
        return (k == 0) ? `CSR_ID_MSCRATCH : 12'h7C0 + 12'(k - 1);
    endfunction

    assign commit = d_is_csr_i & ~x_stall_i & ~x_kill_i;
    assign op2    = d_fun_i[2] ? {27'b0, d_csr_imm_i} : d_rs1_i;

    always_comb begin
        wval = op2;
        unique case (d_fun_i[1:0])
            2'b10:   wval = rd | op2;
            2'b11:   wval = rd & ~op2;
            default: wval = op2;
        endcase
    end

    always_comb begin
        rd = '0;
        case (d_csr_sel_i)
            `CSR_ID_MSTATUS:     rd = csr_mstatus_i;
            `CSR_ID_MIE:         rd = csr_mie_i;
            `CSR_ID_MIP:         rd = csr_mip_i;
            `CSR_ID_MEPC:        rd = csr_mepc_i;
            `CSR_ID_MCAUSE:      rd = csr_mcause_i;
            `CSR_ID_CYCLESL:     rd = cycles_q[31:0];
            `CSR_ID_CYCLESH:     rd = 32'(cycles_q[W-1:32]);
            `CSR_ID_INSTRETL:    rd = instret_l;
            `CSR_ID_INSTRETH:    rd = instret_h;
            `CSR_ID_DBGMBX:      rd = mbx_rd;
            `CSR_ID_DBGMBX_STAT: rd = mbx_stat;
            default:             rd = '0;
        endcase
        for (int k = 0; k < g_num_scratch; k++)
            if (d_csr_sel_i == scr_addr(k))
                rd = scratch_q[k];
    end

    assign x_rd_o              = rd;
    assign x_csr_write_value_o = wval;
    assign csr_cycles_o        = cycles_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < g_num_scratch; k++)
                scratch_q[k] <= '0;
        end else begin
            for (int k = 0; k < g_num_scratch; k++)
                if (commit && d_csr_sel_i == scr_addr(k))
                    scratch_q[k] <= wval;
        end
    end

    // A write to either half replaces it and skips that cycle's tick.
    always_comb begin
        cycles_d = cycles_q + W'(1);
        if (commit && d_csr_sel_i == `CSR_ID_CYCLESL)
            cycles_d = {cycles_q[W-1:32], wval};
        else if (commit && d_csr_sel_i == `CSR_ID_CYCLESH)
            cycles_d = {wval[W-33:0], cycles_q[31:0]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cycles_q <= '0;
        else       cycles_q <= cycles_d;
    end

`ifdef URV_CSR_INSTRET_EN
    logic [W-1:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q + (x_retire_i ? W'(1) : W'(0));
        if (commit && d_csr_sel_i == `CSR_ID_INSTRETL)
            instret_d = {instret_q[W-1:32], wval};
        else if (commit && d_csr_sel_i == `CSR_ID_INSTRETH)
            instret_d = {wval[W-33:0], instret_q[31:0]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) instret_q <= '0;
        else       instret_q <= instret_d;
    end

    assign instret_l = instret_q[31:0];
    assign instret_h = 32'(instret_q[W-1:32]);
`else
    logic unused_retire;
    assign unused_retire = x_retire_i;
    assign instret_l     = '0;
    assign instret_h     = '0;
`endif

    if (g_with_hw_debug != 0) begin : g_mbx
        logic [31:0] fifo0_q, fifo0_d, fifo1_q, fifo1_d;
        logic [1:0]  cnt_q, cnt_d;
        logic [31:0] out_data_q, out_data_d;
        logic        out_valid_q, out_valid_d;
        logic        acc, push, pop;

        assign acc  = commit && d_csr_sel_i == `CSR_ID_DBGMBX;
        assign push = mbx.dbg_mbx_valid_i && cnt_q != 2'd2;
        assign pop  = acc && cnt_q != 2'd0;

        // Shift FIFO: entry 0 is always the head.
        always_comb begin
            fifo0_d = fifo0_q;
            fifo1_d = fifo1_q;
            cnt_d   = cnt_q;
            unique case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) fifo0_d = mbx.dbg_mbx_data_i;
                    else               fifo1_d = mbx.dbg_mbx_data_i;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    fifo0_d = fifo1_q;
                    cnt_d   = cnt_q - 2'd1;
                end
                2'b11:   fifo0_d = mbx.dbg_mbx_data_i;
                default: ;
            endcase
        end

        always_comb begin
            out_data_d  = out_data_q;
            out_valid_d = out_valid_q;
            if (acc && d_fun_i[1:0] == 2'b01) begin
                out_data_d  = wval;
                out_valid_d = 1'b1;
            end else if (mbx.dbg_mbx_ack_i) begin
                out_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                fifo0_q     <= '0;
                fifo1_q     <= '0;
                cnt_q       <= '0;
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                fifo0_q     <= fifo0_d;
                fifo1_q     <= fifo1_d;
                cnt_q       <= cnt_d;
                out_data_q  <= out_data_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign mbx_rd   = (cnt_q != 2'd0) ? fifo0_q : '0;
        assign mbx_stat = {29'b0, out_valid_q, cnt_q == 2'd2, cnt_q != 2'd0};
        assign mbx.dbg_mbx_ready_o = cnt_q != 2'd2;
        assign mbx.dbg_mbx_data_o  = out_data_q;
        assign mbx.dbg_mbx_valid_o = out_valid_q;
    end else begin : g_no_mbx
        logic unused_mbx;
        assign unused_mbx = ^{mbx.dbg_mbx_data_i, mbx.dbg_mbx_valid_i,
                              mbx.dbg_mbx_ack_i};
        assign mbx_rd   = '0;
        assign mbx_stat = '0;
        assign mbx.dbg_mbx_ready_o = 1'b0;
        assign mbx.dbg_mbx_data_o  = '0;
        assign mbx.dbg_mbx_valid_o = 1'b0;
    end
endmodule

// File: tb/tb_urv_csr_bank.sv
// Directed bench for urv_csr_bank with a queue-based scoreboard.
// INSTRETL expectation follows URV_CSR_INSTRET_EN.
module tb_urv_csr_bank;
    localparam int W = 40;

    localparam logic [11:0] A_MSCR = 12'h340;
    localparam logic [11:0] A_MEPC = 12'h341;
    localparam logic [11:0] A_CYL  = 12'hC00;
    localparam logic [11:0] A_CYH  = 12'hC80;
    localparam logic [11:0] A_IRL  = 12'hC02;
    localparam logic [11:0] A_MBX  = 12'h7D0;
    localparam logic [11:0] A_STAT = 12'h7D1;
    localparam logic [11:0] A_SC1  = 12'h7C0;
    localparam logic [11:0] A_SC2  = 12'h7C1;

    localparam logic [2:0] F_RW  = 3'b001;
    localparam logic [2:0] F_RS  = 3'b010;
    localparam logic [2:0] F_RC  = 3'b011;
    localparam logic [2:0] F_RSI = 3'b110;

    localparam int S_RD = 0, S_WV = 1, S_CYC = 2;
    localparam int S_RDY = 3, S_VAL = 4, S_DAT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x_stall, x_kill, x_retire, d_is_csr;
    logic [2:0]  d_fun;
    logic [4:0]  d_imm;
    logic [11:0] d_sel;
    logic [31:0] d_rs1, x_rd, x_wval;
    logic [W-1:0] cycles;

    urv_csr_bank_if mbx_if();

    urv_csr_bank #(
        .g_num_scratch(2), .g_counter_width(W), .g_with_hw_debug(1)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .x_stall_i(x_stall), .x_kill_i(x_kill), .x_retire_i(x_retire),
        .d_is_csr_i(d_is_csr), .d_fun_i(d_fun), .d_csr_imm_i(d_imm),
        .d_csr_sel_i(d_sel), .d_rs1_i(d_rs1),
        .x_rd_o(x_rd), .x_csr_write_value_o(x_wval),
        .csr_mstatus_i(32'h0000_1800), .csr_mip_i(32'h0000_0080),
        .csr_mie_i(32'h0000_0888), .csr_mepc_i(32'hCAFE_0001),
        .csr_mcause_i(32'h8000_0007),
        .csr_cycles_o(cycles),
        .mbx(mbx_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sig;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t mon_e;
    logic [63:0] mon_act;

    function automatic logic [63:0] observe(input int sig);
        case (sig)
            S_RD:    return {32'b0, x_rd};
            S_WV:    return {32'b0, x_wval};
            S_CYC:   return {24'b0, cycles};
            S_RDY:   return {63'b0, mbx_if.dbg_mbx_ready_o};
            S_VAL:   return {63'b0, mbx_if.dbg_mbx_valid_o};
            default: return {32'b0, mbx_if.dbg_mbx_data_o};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_act = observe(mon_e.sig);
            n_cmp++;
            if (mon_act !== mon_e.exp) begin
                n_bad++;
                $display("FAIL %s: got %0h, expected %0h",
                         mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    task automatic exp_push(input int sig, input logic [63:0] v,
                            input string nm);
        exp_t e;
        e.sig  = sig;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        d_is_csr = 1'b0;
        x_stall  = 1'b0;
        x_kill   = 1'b0;
        x_retire = 1'b0;
        mbx_if.dbg_mbx_valid_i = 1'b0;
        mbx_if.dbg_mbx_ack_i   = 1'b0;
    endtask

    task automatic csr(input logic [2:0] f, input logic [11:0] s,
                       input logic [31:0] v);
        d_is_csr = 1'b1;
        d_fun    = f;
        d_sel    = s;
        d_rs1    = v;
        d_imm    = v[4:0];
    endtask

    task automatic push_in(input logic [31:0] v);
        mbx_if.dbg_mbx_valid_i = 1'b1;
        mbx_if.dbg_mbx_data_i  = v;
    endtask

    initial begin
        d_is_csr = 1'b0; x_stall = 1'b0; x_kill = 1'b0; x_retire = 1'b0;
        d_fun = F_RW; d_imm = '0; d_sel = A_MSCR; d_rs1 = '0;
        mbx_if.dbg_mbx_valid_i = 1'b0;
        mbx_if.dbg_mbx_data_i  = '0;
        mbx_if.dbg_mbx_ack_i   = 1'b0;

        // reset: writes and pushes presented now are dropped
        repeat (2) begin
            step(); csr(F_RW, A_MSCR, 32'h1234); push_in(32'h99);
            exp_push(S_RDY, 1, "rst_ready");
            exp_push(S_VAL, 0, "rst_valid_o");
            exp_push(S_DAT, 0, "rst_data_o");
            exp_push(S_CYC, 0, "rst_cycles");
            exp_push(S_RD, 0, "rst_mscratch");
        end
        step(); rst = 1'b0; d_sel = A_MSCR;
        exp_push(S_RD, 0, "post_rst_mscratch");
        exp_push(S_CYC, 0, "post_rst_cycles");
        step(); d_sel = A_STAT;
        exp_push(S_RD, 0, "post_rst_stat");
        exp_push(S_CYC, 1, "cycles_tick");

        // scratch RW / RSI / RC
        step(); csr(F_RW, A_MSCR, 32'hDEADBEEF);
        exp_push(S_RD, 0, "rw_old");
        exp_push(S_WV, 64'hDEADBEEF, "rw_wval");
        step(); csr(F_RSI, A_MSCR, 32'h10);
        exp_push(S_RD, 64'hDEADBEEF, "rsi_old");
        exp_push(S_WV, 64'hDEADBEFF, "rsi_wval");
        step(); csr(F_RC, A_MSCR, 32'h0000000F);
        exp_push(S_RD, 64'hDEADBEFF, "rc_old");
        exp_push(S_WV, 64'hDEADBEF0, "rc_wval");
        step(); csr(F_RW, A_MSCR, 32'h1); x_stall = 1'b1;
        exp_push(S_RD, 64'hDEADBEF0, "rc_result");
        step(); csr(F_RW, A_MSCR, 32'h2); x_kill = 1'b1;
        exp_push(S_RD, 64'hDEADBEF0, "stalled_write");
        step(); d_sel = A_MSCR;
        exp_push(S_RD, 64'hDEADBEF0, "killed_write");

        // second scratch, unimplemented scratch, unlisted, external
        step(); csr(F_RW, A_SC1, 32'hA5A5);
        exp_push(S_RD, 0, "sc1_old");
        step(); d_sel = A_SC1;
        exp_push(S_RD, 64'hA5A5, "sc1_new");
        step(); csr(F_RW, A_SC2, 32'h1234);
        exp_push(S_RD, 0, "sc2_old");
        step(); d_sel = A_SC2;
        exp_push(S_RD, 0, "sc2_unimpl");
        step(); csr(F_RW, 12'h123, 32'h5);
        exp_push(S_RD, 0, "unlisted_rd");
        exp_push(S_WV, 5, "unlisted_wval");
        step(); d_sel = A_MEPC;
        exp_push(S_RD, 64'hCAFE0001, "mepc");

        // cycle counter wrap
        step(); csr(F_RW, A_CYL, 32'hFFFFFFFF);
        step(); csr(F_RW, A_CYH, 32'hFF);
        exp_push(S_CYC, 64'h00FFFFFFFF, "cyl_write");
        step(); d_sel = A_CYH;
        exp_push(S_CYC, 64'hFFFFFFFFFF, "cyh_write_noinc");
        exp_push(S_RD, 64'hFF, "cyh_read");
        step(); d_sel = A_CYH;
        exp_push(S_CYC, 0, "cycles_wrap");
        exp_push(S_RD, 0, "cyh_wrap");
        step(); d_sel = A_CYL;
        exp_push(S_RD, 1, "cyl_after_wrap");

        // inbound mailbox fill / drain
        step(); push_in(32'h11);
        exp_push(S_RDY, 1, "mbx_rdy0");
        step(); push_in(32'h22);
        exp_push(S_RDY, 1, "mbx_rdy1");
        step(); push_in(32'h33); d_sel = A_STAT;
        exp_push(S_RDY, 0, "mbx_full");
        exp_push(S_RD, 3, "stat_full");
        step(); csr(F_RSI, A_MBX, 32'h0);
        exp_push(S_RD, 64'h11, "mbx_pop1");
        step(); csr(F_RSI, A_MBX, 32'h0);
        exp_push(S_RD, 64'h22, "mbx_pop2");
        exp_push(S_RDY, 1, "mbx_rdy_after_pop");
        step(); csr(F_RSI, A_MBX, 32'h0);
        exp_push(S_RD, 0, "mbx_pop_empty");
        step(); d_sel = A_STAT;
        exp_push(S_RD, 0, "stat_empty");

        // simultaneous push and pop
        step(); push_in(32'hA1);
        step(); push_in(32'hA2); csr(F_RSI, A_MBX, 32'h0);
        exp_push(S_RD, 64'hA1, "pp_head");
        step(); csr(F_RSI, A_MBX, 32'h0);
        exp_push(S_RD, 64'hA2, "pp_order");
        step(); d_sel = A_STAT;
        exp_push(S_RD, 0, "pp_empty");

        // outbound message vs ack
        step(); csr(F_RW, A_MBX, 32'h77);
        exp_push(S_VAL, 0, "out_idle");
        step();
        exp_push(S_VAL, 1, "out_valid");
        exp_push(S_DAT, 64'h77, "out_data");
        step(); csr(F_RW, A_MBX, 32'h55);
        mbx_if.dbg_mbx_ack_i = 1'b1;
        step(); mbx_if.dbg_mbx_ack_i = 1'b1; d_sel = A_STAT;
        exp_push(S_VAL, 1, "load_beats_ack");
        exp_push(S_DAT, 64'h55, "load_data");
        exp_push(S_RD, 4, "stat_out_valid");
        step();
        exp_push(S_VAL, 0, "ack_clears");
        exp_push(S_DAT, 64'h55, "ack_keeps_data");

        // instret
        repeat (10) begin
            step(); x_retire = 1'b1;
        end
        step(); d_sel = A_IRL;
`ifdef URV_CSR_INSTRET_EN
        exp_push(S_RD, 10, "instret");
`else
        exp_push(S_RD, 0, "instret");
`endif

        // asynchronous reset during a push
        step(); csr(F_RW, A_MBX, 32'h66); push_in(32'h44);
        step(); d_sel = A_STAT;
        exp_push(S_RD, 5, "stat_before_rst");
        step(); push_in(32'h45); csr(F_RW, A_MSCR, 32'h777);
        #1 rst = 1'b1;
        exp_push(S_VAL, 0, "async_rst_valid");
        exp_push(S_DAT, 0, "async_rst_data");
        exp_push(S_RDY, 1, "async_rst_ready");
        exp_push(S_CYC, 0, "async_rst_cycles");
        exp_push(S_RD, 0, "async_rst_mscratch");
        step(); push_in(32'h46);
        step(); rst = 1'b0; d_sel = A_STAT;
        exp_push(S_RD, 0, "rst_fifo_empty");
        step(); d_sel = A_MSCR;
        exp_push(S_RD, 0, "rst_mscratch_clear");

        step();
        step();
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0",
                     sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
